monolith_axis_chunk_fifo_sif: RTL and testbench

AXI4-Stream sink that packs incoming beats into fixed-size chunks and presents one whole chunk in parallel to the compute core.
It is the parametrised successor of the single-chunk-read slave interface, with these additions:
- no idle cycle per TVALID;
- TLAST-terminated short chunks with padding;
- TSTRB byte masking;
- per-chunk metadata;
- an occupancy count.
It sits between the DMA MM2S stream and the core's parallel operand register.

---
 rtl/monolith_axis_chunk_fifo_sif.sv | 147 ++++++++++++++
 tb/tb_monolith_axis_chunk_fifo_sif.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/monolith_axis_chunk_fifo_sif.sv
// AXI4-Stream sink packing beats into fixed-size chunks, popped whole onto a parallel bus.
// Pop latency 1 cycle; TREADY drops only when every chunk slot is committed (full throughput otherwise).
module monolith_axis_chunk_fifo_sif #(
   parameter int FIFO_CHUNK_SIZE      = 16,
   parameter int FIFO_CHUNK_COUNT     = 4,
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter bit TLAST_CLOSES_CHUNK   = 1'b1,
   parameter logic [C_S_AXIS_TDATA_WIDTH-1:0] PAD_VALUE = '0
) (
   input  logic                                                   S_AXIS_ACLK,
   input  logic                                                   S_AXIS_ARESETN,
   output logic                                                   S_AXIS_TREADY,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]                        S_AXIS_TDATA,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]                      S_AXIS_TSTRB,
   input  logic                                                   S_AXIS_TLAST,
   input  logic                                                   S_AXIS_TVALID,
   input  logic                                                   fifo_read_strobe,
   output logic [FIFO_CHUNK_SIZE-1:0][C_S_AXIS_TDATA_WIDTH-1:0]   fifo_out,
   output logic                                                   fifo_out_valid,
   output logic [$clog2(FIFO_CHUNK_SIZE):0]                       fifo_out_count,
   output logic                                                   fifo_out_last,
   output logic                                                   fifo_empty,
   output logic                                                   fifo_full,
   output logic [$clog2(FIFO_CHUNK_COUNT):0]                      fifo_level
);

   localparam int W      = C_S_AXIS_TDATA_WIDTH;
   localparam int STRB_W = W / 8;
   localparam int IDX_W  = $clog2(FIFO_CHUNK_SIZE);
   localparam int CNT_W  = IDX_W + 1;
   localparam int PTR_W  = $clog2(FIFO_CHUNK_COUNT) + 1;
   localparam int SEL_W  = PTR_W - 1;

   typedef logic [W-1:0] word_t;
   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             last;
   } meta_t;

   word_t mem_q  [FIFO_CHUNK_COUNT][FIFO_CHUNK_SIZE];
   meta_t meta_q [FIFO_CHUNK_COUNT];

   logic [PTR_W-1:0] wr_chunk_q, wr_chunk_d;
   logic [PTR_W-1:0] rd_chunk_q, rd_chunk_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic             rdy_q;
   logic [FIFO_CHUNK_SIZE-1:0][W-1:0] out_dat_q, out_dat_d;
   logic             out_vld_q;
   logic [CNT_W-1:0] out_cnt_q;
   logic             out_last_q;

   logic [PTR_W-1:0] level;
   logic             full, empty;
   logic             beat_acc, commit, pop;
   word_t            beat_dat;
   meta_t            wr_meta, rd_meta;
   logic [SEL_W-1:0] wr_sel, rd_sel;

   assign level  = wr_chunk_q - rd_chunk_q;
   assign full   = (level == PTR_W'(FIFO_CHUNK_COUNT));
   assign empty  = (level == '0);
   assign wr_sel = wr_chunk_q[SEL_W-1:0];
   assign rd_sel = rd_chunk_q[SEL_W-1:0];

   // rdy_q keeps TREADY low in reset and for the first cycle after it; full is pointer-derived only.
   assign S_AXIS_TREADY = rdy_q && !full;
   assign beat_acc      = S_AXIS_TVALID && S_AXIS_TREADY;
   assign commit        = beat_acc && ((wr_idx_q == IDX_W'(FIFO_CHUNK_SIZE - 1)) ||
                                       (TLAST_CLOSES_CHUNK && S_AXIS_TLAST));
   assign pop           = fifo_read_strobe && !empty;

   always_comb begin
      beat_dat = '0;
      for (int b = 0; b < STRB_W; b++) begin
         beat_dat[8*b +: 8] = S_AXIS_TSTRB[b] ? S_AXIS_TDATA[8*b +: 8] : 8'h00;
      end
   end

   always_comb begin
      wr_meta.cnt  = CNT_W'(wr_idx_q) + CNT_W'(1);
      wr_meta.last = TLAST_CLOSES_CHUNK && S_AXIS_TLAST;
      rd_meta      = meta_q[rd_sel];
      out_dat_d    = '0;
      for (int i = 0; i < FIFO_CHUNK_SIZE; i++) begin
         out_dat_d[i] = (CNT_W'(i) < rd_meta.cnt) ? mem_q[rd_sel][i] : PAD_VALUE;
      end
   end

   always_comb begin
      wr_chunk_d = wr_chunk_q;
      rd_chunk_d = rd_chunk_q;
      wr_idx_d   = wr_idx_q;
      if (beat_acc) begin
         wr_idx_d = wr_idx_q + IDX_W'(1);
      end
      if (commit) begin
         wr_chunk_d = wr_chunk_q + PTR_W'(1);
         wr_idx_d   = '0;
      end
      if (pop) begin
         rd_chunk_d = rd_chunk_q + PTR_W'(1);
      end
   end

   // Storage is deliberately left unreset; metadata gates what is ever exposed.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (beat_acc) begin
         mem_q[wr_sel][wr_idx_q] <= beat_dat;
      end
      if (commit) begin
         meta_q[wr_sel] <= wr_meta;
      end
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         wr_chunk_q <= '0;
         rd_chunk_q <= '0;
         wr_idx_q   <= '0;
         rdy_q      <= 1'b0;
         out_dat_q  <= '0;
         out_vld_q  <= 1'b0;
         out_cnt_q  <= '0;
         out_last_q <= 1'b0;
      end else begin
         wr_chunk_q <= wr_chunk_d;
         rd_chunk_q <= rd_chunk_d;
         wr_idx_q   <= wr_idx_d;
         rdy_q      <= 1'b1;
         out_vld_q  <= pop;
         if (pop) begin
            out_dat_q  <= out_dat_d;
            out_cnt_q  <= rd_meta.cnt;
            out_last_q <= rd_meta.last;
         end
      end
   end

   assign fifo_out       = out_dat_q;
   assign fifo_out_valid = out_vld_q;
   assign fifo_out_count = out_cnt_q;
   assign fifo_out_last  = out_last_q;
   assign fifo_empty     = empty;
   assign fifo_full      = full;
   assign fifo_level     = level;

endmodule

// File: tb/tb_monolith_axis_chunk_fifo_sif.sv
// Directed bench: two instances (TLAST closes / ignored), SIZE=4, COUNT=2, PAD=0xDEAD.
module tb_monolith_axis_chunk_fifo_sif;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance A: TLAST closes chunks
   logic a_rdy, a_last, a_vld, a_rs, a_ovld, a_olast, a_empty, a_full;
   logic [31:0] a_dat;
   logic [3:0]  a_strb;
   logic [3:0][31:0] a_out;
   logic [2:0]  a_ocnt;
   logic [1:0]  a_lvl;

   // instance B: TLAST ignored
   logic b_rdy, b_last, b_vld, b_rs, b_ovld, b_olast, b_empty, b_full;
   logic [31:0] b_dat;
   logic [3:0]  b_strb;
   logic [3:0][31:0] b_out;
   logic [2:0]  b_ocnt;
   logic [1:0]  b_lvl;

   monolith_axis_chunk_fifo_sif #(
      .FIFO_CHUNK_SIZE(4), .FIFO_CHUNK_COUNT(2), .C_S_AXIS_TDATA_WIDTH(32),
      .TLAST_CLOSES_CHUNK(1'b1), .PAD_VALUE(32'h0000DEAD)
   ) dut_a (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TREADY(a_rdy),
      .S_AXIS_TDATA(a_dat), .S_AXIS_TSTRB(a_strb), .S_AXIS_TLAST(a_last),
      .S_AXIS_TVALID(a_vld), .fifo_read_strobe(a_rs), .fifo_out(a_out),
      .fifo_out_valid(a_ovld), .fifo_out_count(a_ocnt), .fifo_out_last(a_olast),
      .fifo_empty(a_empty), .fifo_full(a_full), .fifo_level(a_lvl)
   );

   monolith_axis_chunk_fifo_sif #(
      .FIFO_CHUNK_SIZE(4), .FIFO_CHUNK_COUNT(2), .C_S_AXIS_TDATA_WIDTH(32),
      .TLAST_CLOSES_CHUNK(1'b0), .PAD_VALUE(32'h0000DEAD)
   ) dut_b (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TREADY(b_rdy),
      .S_AXIS_TDATA(b_dat), .S_AXIS_TSTRB(b_strb), .S_AXIS_TLAST(b_last),
      .S_AXIS_TVALID(b_vld), .fifo_read_strobe(b_rs), .fifo_out(b_out),
      .fifo_out_valid(b_ovld), .fifo_out_count(b_ocnt), .fifo_out_last(b_olast),
      .fifo_empty(b_empty), .fifo_full(b_full), .fifo_level(b_lvl)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
      a_vld = 1'b1; a_dat = d; a_strb = s; a_last = l;
      tick();
      a_vld = 1'b0; a_last = 1'b0;
   endtask

   task automatic b_beat(input logic [31:0] d, input logic l);
      b_vld = 1'b1; b_dat = d; b_strb = 4'hF; b_last = l;
      tick();
      b_vld = 1'b0; b_last = 1'b0;
   endtask

   task automatic a_chunk(input logic [31:0] base);
      for (int w = 0; w < 4; w++) a_beat(base + 32'(w), 4'hF, 1'b0);
   endtask

   task automatic a_pop();
      a_rs = 1'b1;
      tick();
      a_rs = 1'b0;
   endtask

   logic [127:0] e;

   initial begin
      a_vld = 0; a_dat = 0; a_strb = 0; a_last = 0; a_rs = 0;
      b_vld = 0; b_dat = 0; b_strb = 0; b_last = 0; b_rs = 0;
      tick();
      // reset state
      chk("rst_rdy", a_rdy, 1'b0);
      chk("rst_empty", a_empty, 1'b1);
      chk("rst_full", a_full, 1'b0);
      chk("rst_lvl", a_lvl, 2'd0);
      chk("rst_ovld", a_ovld, 1'b0);
      chk("rst_out", a_out, 128'h0);
      chk("rst_cnt", a_ocnt, 3'd0);
      rst_n = 1'b1;
      chk("rdy_delay", a_rdy, 1'b0);
      tick();
      chk("rdy_after_rst", a_rdy, 1'b1);

      // strobe while empty
      a_rs = 1'b1; tick(); a_rs = 1'b0;
      chk("empty_pop_vld", a_ovld, 1'b0);
      chk("empty_pop_out", a_out, 128'h0);

      // back-to-back fill to full
      for (int i = 0; i < 8; i++) begin
         a_vld = 1'b1; a_dat = 32'h10 + 32'(i); a_strb = 4'hF; a_last = 1'b0;
         chk($sformatf("b2b_rdy%0d", i), a_rdy, 1'b1);
         tick();
      end
      a_vld = 1'b0;
      chk("fill_full", a_full, 1'b1);
      chk("fill_rdy", a_rdy, 1'b0);
      chk("fill_lvl", a_lvl, 2'd2);
      a_pop();
      chk("pop1_out", a_out, 128'h00000013_00000012_00000011_00000010);
      chk("pop1_vld", a_ovld, 1'b1);
      chk("pop1_cnt", a_ocnt, 3'd4);
      chk("pop1_last", a_olast, 1'b0);
      chk("pop1_lvl", a_lvl, 2'd1);
      chk("pop1_rdy", a_rdy, 1'b1);
      tick();
      chk("pulse_end", a_ovld, 1'b0);
      chk("hold_out", a_out, 128'h00000013_00000012_00000011_00000010);
      a_pop();
      chk("pop2_out", a_out, 128'h00000017_00000016_00000015_00000014);
      chk("pop2_empty", a_empty, 1'b1);

      // TLAST short chunk with padding
      a_beat(32'hA, 4'hF, 1'b0);
      a_beat(32'hB, 4'hF, 1'b1);
      chk("short_lvl", a_lvl, 2'd1);
      a_pop();
      chk("short_out", a_out, 128'h0000DEAD_0000DEAD_0000000B_0000000A);
      chk("short_cnt", a_ocnt, 3'd2);
      chk("short_last", a_olast, 1'b1);

      // full chunk whose final beat has TLAST
      a_beat(32'h1, 4'hF, 1'b0);
      a_beat(32'h2, 4'hF, 1'b0);
      a_beat(32'h3, 4'hF, 1'b0);
      a_beat(32'h4, 4'hF, 1'b1);
      a_pop();
      chk("fl_out", a_out, 128'h00000004_00000003_00000002_00000001);
      chk("fl_cnt", a_ocnt, 3'd4);
      chk("fl_last", a_olast, 1'b1);

      // TLAST ignored on instance B
      b_beat(32'hA, 1'b0);
      b_beat(32'hB, 1'b1);
      chk("b_lvl_partial", b_lvl, 2'd0);
      b_beat(32'hC, 1'b0);
      b_beat(32'hD, 1'b0);
      chk("b_lvl_full", b_lvl, 2'd1);
      b_rs = 1'b1; tick(); b_rs = 1'b0;
      chk("b_out", b_out, 128'h0000000D_0000000C_0000000B_0000000A);
      chk("b_cnt", b_ocnt, 3'd4);
      chk("b_last", b_olast, 1'b0);
      chk("b_vld", b_ovld, 1'b1);

      // byte masking
      a_beat(32'hAABBCCDD, 4'b0101, 1'b1);
      a_pop();
      chk("strb_out", a_out, 128'h0000DEAD_0000DEAD_0000DEAD_00BB00DD);
      chk("strb_cnt", a_ocnt, 3'd1);

      // commit and pop in the same cycle
      a_chunk(32'h20);
      a_beat(32'h30, 4'hF, 1'b0);
      a_beat(32'h31, 4'hF, 1'b0);
      a_beat(32'h32, 4'hF, 1'b0);
      a_vld = 1'b1; a_dat = 32'h33; a_strb = 4'hF; a_rs = 1'b1;
      tick();
      a_vld = 1'b0; a_rs = 1'b0;
      chk("cp_lvl", a_lvl, 2'd1);
      chk("cp_rdy", a_rdy, 1'b1);
      chk("cp_vld", a_ovld, 1'b1);
      chk("cp_out", a_out, 128'h00000023_00000022_00000021_00000020);
      a_pop();
      chk("cp_out2", a_out, 128'h00000033_00000032_00000031_00000030);
      chk("cp_empty", a_empty, 1'b1);

      // five chunks through the wrap
      for (int c = 0; c < 5; c++) begin
         a_chunk(32'(c * 16));
         chk($sformatf("wrap_lvl%0d", c), a_lvl, 2'd1);
         a_pop();
         for (int w = 0; w < 4; w++) e[w*32 +: 32] = 32'(c * 16 + w);
         chk($sformatf("wrap_out%0d", c), a_out, e);
      end

      // reset mid-chunk
      a_chunk(32'h50);
      a_beat(32'h60, 4'hF, 1'b0);
      a_beat(32'h61, 4'hF, 1'b0);
      chk("pre_rst_lvl", a_lvl, 2'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_lvl", a_lvl, 2'd0);
      chk("arst_empty", a_empty, 1'b1);
      chk("arst_rdy", a_rdy, 1'b0);
      chk("arst_out", a_out, 128'h0);
      tick();
      rst_n = 1'b1;
      chk("rel_rdy0", a_rdy, 1'b0);
      tick();
      chk("rel_rdy1", a_rdy, 1'b1);
      a_chunk(32'h70);
      chk("post_rst_lvl", a_lvl, 2'd1);
      a_pop();
      chk("post_rst_out", a_out, 128'h00000073_00000072_00000071_00000070);
      chk("post_rst_cnt", a_ocnt, 3'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
